// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM state encoding shared by the ALU, the arbiter and benches.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_LESS = 3'd1;
    localparam logic [2:0] OP_EQ   = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_NOT  = 3'd5;
    localparam logic [2:0] OP_MAX  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response bus between client units and the shared ALU.
interface alu_share_arbiter_if #(
    parameter int N    = 32,
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_opcode;
    logic [N*NREQ-1:0] req_a;
    logic [N*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_result;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_opcode, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy
    );

endinterface

// File: rtl/alu.sv
// alu: combinational ADD/LESS/EQ/OR/AND/NOT unit; unknown opcodes yield zero.
module alu
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [2:0]   op_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] result_o
);

    always_comb begin
        result_o = op_i == OP_ADD  ? a_i + b_i :
                   op_i == OP_LESS ? N'(a_i < b_i) :
                   op_i == OP_EQ   ? N'(a_i == b_i) :
                   op_i == OP_OR   ? a_i | b_i :
                   op_i == OP_AND  ? a_i & b_i :
                   op_i == OP_NOT  ? ~a_i : '0;
    end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr_i.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o
);

    // Scan farthest-first so the nearest requester from ptr_i is written last and wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % NREQ]) idx_o = IDW'((int'(ptr_i) + k) % NREQ);
        end
        grant_o[idx_o] = |req_i;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU among NREQ requesters,
// one operation in flight, tagged response held until consumed.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREQ = 4
) (
    input logic                clk,
    input logic                rst,
    alu_share_arbiter_if.slave bus
);

    localparam int IDW = $clog2(NREQ);

    state_e          state_q;
    logic [IDW-1:0]  ptr_q, ptr_d, id_q, gnt_idx, rsp_id_q;
    logic [NREQ-1:0] gnt;
    logic [2:0]      op_q;
    logic [N-1:0]    a_q, b_q, alu_res, rsp_result_q;
    logic            rsp_valid_q, rsp_err_q, accept;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i  (bus.req_valid),
        .ptr_i  (ptr_q),
        .grant_o(gnt),
        .idx_o  (gnt_idx)
    );

    alu #(.N(N)) u_alu (
        .op_i    (op_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .result_o(alu_res)
    );

    assign accept         = state_q == S_IDLE && |bus.req_valid && !rst;
    assign ptr_d          = gnt_idx == IDW'(NREQ - 1) ? '0 : gnt_idx + 1'b1;
    assign bus.req_ready  = accept ? gnt : '0;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = state_q != S_IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    op_q    <= bus.req_opcode[3*gnt_idx +: 3];
                    a_q     <= bus.req_a[N*gnt_idx +: N];
                    b_q     <= bus.req_b[N*gnt_idx +: N];
                    id_q    <= gnt_idx;
                    ptr_q   <= ptr_d;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    rsp_result_q <= op_q > OP_MAX ? '0 : alu_res;
                    rsp_err_q    <= op_q > OP_MAX;
                    rsp_id_q     <= id_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: if (bus.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
